led_bar_monitor: RTL and testbench

LED_BAR_MONITOR -- requirements
Module: led_bar_monitor

---
 rtl/led_bar_monitor.sv | 96 +++++++++
 tb/tb_led_bar_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_bar_monitor.sv
// led_bar_monitor: tracks a thermometer LED bar (led) and reports level, dir, turn/turn_level, cycle_done/cycle_cnt and sticky err/err_code
module led_bar_monitor #(
  parameter int N_LED = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_LED-1:0] led,
  input  logic             enable,
  output logic [4:0]       level,
  output logic [1:0]       dir,
  output logic             turn,
  output logic [4:0]       turn_level,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err,
  output logic [1:0]       err_code
);
  typedef enum logic [1:0] {IDLE, RISE, FALL, ERR} state_t;
  state_t state, state_n;
  logic [N_LED-1:0] led_q;
  logic en_q, en_qq;
  logic [4:0] k, level_n, turn_level_n;
  logic turn_n, cycle_done_n, err_n;
  logic [1:0] err_code_n;
  logic [CNT_W-1:0] cycle_cnt_n;
  logic valid, up, same, dn, step;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      en_q <= 1'b0;
      en_qq <= 1'b0;
      level <= '0;
      turn <= 1'b0;
      turn_level <= '0;
      cycle_done <= 1'b0;
      cycle_cnt <= '0;
      err <= 1'b0;
      err_code <= '0;
    end else begin
      led_q <= led;
      en_q <= enable;
      en_qq <= en_q;
      level <= level_n;
      turn <= turn_n;
      turn_level <= turn_level_n;
      cycle_done <= cycle_done_n;
      cycle_cnt <= cycle_cnt_n;
      err <= err_n;
      err_code <= err_code_n;
    end
  end
  always_comb begin
    k = '0;
    for (int i = 0; i < N_LED; i++) k = k + 5'(led_q[i]);
    valid = (led_q & (led_q + N_LED'(1))) == '0;
    up = k == level + 5'd1;
    same = k == level;
    dn = k + 5'd1 == level;
    step = ~(up | same | dn);
    state_n = state;
    level_n = level;
    turn_n = 1'b0;
    turn_level_n = turn_level;
    cycle_done_n = 1'b0;
    cycle_cnt_n = cycle_cnt;
    err_n = err;
    err_code_n = err_code;
    if (!en_q) begin
      state_n = state == ERR ? ERR : IDLE;
      level_n = state == ERR ? level : '0;
    end else if (!en_qq || state == ERR) begin
      level_n = valid ? k : level;
    end else if (!valid || step) begin
      state_n = ERR;
      err_n = 1'b1;
      err_code_n = {valid & step, ~valid};
    end else if (up) begin
      state_n = RISE;
      level_n = k;
      turn_n = state == FALL;
      turn_level_n = state == FALL ? level : turn_level;
    end else if (dn) begin
      level_n = k;
      state_n = k == '0 ? IDLE : FALL;
      turn_n = k != '0 && state == RISE;
      turn_level_n = turn_n ? level : turn_level;
      cycle_done_n = k == '0 && state != IDLE;
      cycle_cnt_n = cycle_done_n && !(&cycle_cnt) ? cycle_cnt + CNT_W'(1) : cycle_cnt;
    end
  end
  always_comb dir = state == RISE ? 2'b01 : state == FALL ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_led_bar_monitor.sv
// tb_led_bar_monitor: randomized and directed scoreboard bench for led_bar_monitor
module tb_led_bar_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [15:0] led = '0;
  logic [4:0] level, turn_level;
  logic [1:0] dir, err_code;
  logic turn, cycle_done, err;
  logic [7:0] cycle_cnt;
  always #5 clk = ~clk;
  led_bar_monitor #(.N_LED(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .led(led), .enable(enable),
    .level(level), .dir(dir), .turn(turn), .turn_level(turn_level),
    .cycle_done(cycle_done), .cycle_cnt(cycle_cnt), .err(err), .err_code(err_code)
  );
  typedef struct packed {
    logic [4:0] level;
    logic [1:0] dir;
    logic turn;
    logic [4:0] tl;
    logic done;
    logic [7:0] cnt;
    logic err;
    logic [1:0] code;
  } obs_t;
  obs_t exp_q[$];
  obs_t got, want;
  int checks = 0, failures = 0, n_turn = 0, n_done = 0;
  int m_state = 0, m_level = 0, m_tl = 0, m_cnt = 0, m_code = 0;
  bit m_err = 0, m_en1 = 0, m_en2 = 0;
  logic [15:0] m_ledq = '0;
  function automatic logic [15:0] therm(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction
  task automatic drive(input logic r, input logic en, input logic [15:0] l);
    obs_t e;
    int k;
    bit m_turn, m_done;
    @(negedge clk);
    rst = r;
    enable = en;
    led = l;
    m_turn = 0;
    m_done = 0;
    if (r) begin
      m_state = 0; m_level = 0; m_tl = 0; m_cnt = 0; m_err = 0; m_code = 0;
      m_en1 = 0; m_en2 = 0; m_ledq = '0;
    end else begin
      k = -1;
      for (int j = 0; j <= 16; j++) if (m_ledq == therm(j)) k = j;
      if (!m_en1) begin
        if (m_state != 3) begin m_state = 0; m_level = 0; end
      end else if (!m_en2 || m_state == 3) begin
        if (k >= 0) m_level = k;
      end else if (k < 0 || k > m_level + 1 || k < m_level - 1) begin
        m_state = 3; m_err = 1; m_code = k < 0 ? 1 : 2;
      end else if (k > m_level) begin
        if (m_state == 2) begin m_turn = 1; m_tl = m_level; end
        m_state = 1;
        m_level = k;
      end else if (k < m_level) begin
        if (k == 0) begin
          m_done = m_state != 0;
          if (m_done && m_cnt < 255) m_cnt++;
          m_state = 0;
        end else begin
          if (m_state == 1) begin m_turn = 1; m_tl = m_level; end
          m_state = 2;
        end
        m_level = k;
      end
      m_en2 = m_en1;
      m_en1 = en;
      m_ledq = l;
    end
    e.level = 5'(m_level);
    e.dir = m_state == 1 ? 2'b01 : m_state == 2 ? 2'b10 : 2'b00;
    e.turn = m_turn;
    e.tl = 5'(m_tl);
    e.done = m_done;
    e.cnt = 8'(m_cnt);
    e.err = m_err;
    e.code = 2'(m_code);
    exp_q.push_back(e);
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (turn) n_turn++;
    if (cycle_done) n_done++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {level, dir, turn, turn_level, cycle_done, cycle_cnt, err, err_code};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL scoreboard t=%0t got lvl=%0d dir=%0d turn=%0d tl=%0d done=%0d cnt=%0d err=%0d code=%0d exp lvl=%0d dir=%0d turn=%0d tl=%0d done=%0d cnt=%0d err=%0d code=%0d",
          $time, got.level, got.dir, got.turn, got.tl, got.done, got.cnt, got.err, got.code,
          want.level, want.dir, want.turn, want.tl, want.done, want.cnt, want.err, want.code);
      end
    end
  end
  initial begin
    int t0, d0, sl, r, w;
    repeat (3) drive(1, 0, '0);
    t0 = n_turn; d0 = n_done;
    for (int i = 0; i <= 6; i++) drive(0, 1, therm(i));
    for (int i = 5; i >= 0; i--) drive(0, 1, therm(i));
    repeat (3) drive(0, 1, '0);
    chk("sweep_cnt", cycle_cnt, 1);
    chk("sweep_tl", turn_level, 6);
    chk("sweep_turns", n_turn - t0, 1);
    chk("sweep_dones", n_done - d0, 1);
    repeat (2) drive(1, 1, '0);
    t0 = n_turn; d0 = n_done;
    for (int i = 0; i <= 10; i++) drive(0, 1, therm(i));
    for (int i = 9; i >= 5; i--) drive(0, 1, therm(i));
    for (int i = 6; i <= 16; i++) drive(0, 1, therm(i));
    for (int i = 15; i >= 0; i--) drive(0, 1, therm(i));
    repeat (3) drive(0, 1, '0);
    chk("kick_cnt", cycle_cnt, 1);
    chk("kick_tl", turn_level, 16);
    chk("kick_turns", n_turn - t0, 3);
    chk("kick_err", err, 0);
    repeat (2) drive(1, 1, '0);
    t0 = n_turn; d0 = n_done;
    for (int i = 0; i <= 2; i++) drive(0, 1, therm(i));
    drive(0, 1, 16'h0005);
    for (int i = 2; i <= 3; i++) drive(0, 1, therm(i));
    for (int i = 2; i >= 0; i--) drive(0, 1, therm(i));
    repeat (3) drive(0, 1, '0);
    chk("inv_err", err, 1);
    chk("inv_code", err_code, 1);
    chk("inv_dir", dir, 0);
    chk("inv_pulses", (n_turn - t0) + (n_done - d0), 0);
    repeat (2) drive(1, 1, '0);
    for (int i = 0; i <= 3; i++) drive(0, 1, therm(i));
    drive(0, 1, 16'h00FF);
    repeat (3) drive(0, 1, 16'h0007);
    chk("jump_err", err, 1);
    chk("jump_code", err_code, 2);
    chk("jump_level", level, 3);
    repeat (2) drive(1, 1, '0);
    t0 = n_turn;
    for (int i = 0; i <= 7; i++) drive(0, 1, therm(i));
    drive(1, 1, therm(7));
    repeat (4) drive(0, 1, therm(7));
    chk("rst_level", level, 7);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    chk("rst_turns", n_turn - t0, 0);
    repeat (2) drive(1, 1, '0);
    repeat (2) drive(0, 1, '0);
    d0 = n_done;
    repeat (256) begin drive(0, 1, therm(1)); drive(0, 1, '0); end
    repeat (3) drive(0, 1, '0);
    chk("sat_cnt", cycle_cnt, 255);
    chk("sat_dones", n_done - d0, 256);
    drive(0, 1, therm(1));
    repeat (4) drive(0, 1, '0);
    chk("sat_hold", cycle_cnt, 255);
    chk("sat_pulse", n_done - d0, 257);
    repeat (2) drive(1, 1, '0);
    sl = 0;
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin sl = 0; drive(1, 1, '0); end
      else if (r < 6) drive(0, 0, therm(sl));
      else if (r < 8) drive(0, 1, 16'($urandom));
      else if (r < 10) begin sl = $urandom_range(0, 16); drive(0, 1, therm(sl)); end
      else begin
        sl = sl + $urandom_range(0, 2) - 1;
        sl = sl < 0 ? 0 : sl > 16 ? 16 : sl;
        drive(0, 1, therm(sl));
      end
    end
    repeat (3) drive(0, 0, '0);
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin @(negedge clk); w++; end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
